// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: binary-angle atan table, gain inverse, quadrant angles, FSM encoding.
// Angles are 32-bit binary angles where 2^32 equals a full circle.
package cordic_pkg;

  localparam logic [15:0] KINV      = 16'h4DBA;
  localparam logic [31:0] ANGLE_90  = 32'h4000_0000;
  localparam logic [31:0] ANGLE_M90 = 32'hC000_0000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_SCALE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ROTATE = ST_ROTATE,
    SCALE  = ST_SCALE
  } state_t;

  // round(atan(2^-i) * 2^32 / (2*pi)) for i = 0..23
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    logic [31:0] a;
    case (i)
      5'd0:    a = 32'h2000_0000;
      5'd1:    a = 32'h12E4_051E;
      5'd2:    a = 32'h09FB_385B;
      5'd3:    a = 32'h0511_11D4;
      5'd4:    a = 32'h028B_0D43;
      5'd5:    a = 32'h0145_D7E1;
      5'd6:    a = 32'h00A2_F61E;
      5'd7:    a = 32'h0051_7C55;
      5'd8:    a = 32'h0028_BE53;
      5'd9:    a = 32'h0014_5F2F;
      5'd10:   a = 32'h000A_2F98;
      5'd11:   a = 32'h0005_17CC;
      5'd12:   a = 32'h0002_8BE6;
      5'd13:   a = 32'h0001_45F3;
      5'd14:   a = 32'h0000_A2FA;
      5'd15:   a = 32'h0000_517D;
      5'd16:   a = 32'h0000_28BE;
      5'd17:   a = 32'h0000_145F;
      5'd18:   a = 32'h0000_0A30;
      5'd19:   a = 32'h0000_0518;
      5'd20:   a = 32'h0000_028C;
      5'd21:   a = 32'h0000_0146;
      5'd22:   a = 32'h0000_00A3;
      5'd23:   a = 32'h0000_0051;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One CORDIC micro-rotation, combinational; ccw=1 rotates +atan(2^-shift) (z decreases).
// No state, no backpressure; vectoring drives ccw from sign(y), rotation from sign(z).
module cordic_microrot #(
  parameter int W = 22
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic        [31:0]  z,
  input  logic        [4:0]   shift,
  input  logic                ccw,
  input  logic        [31:0]  atan,
  output logic signed [W-1:0] x_rot,
  output logic signed [W-1:0] y_rot,
  output logic        [31:0]  z_rot
);

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    if (ccw) begin
      x_rot = x - ys;
      y_rot = y + xs;
      z_rot = z - atan;
    end else begin
      x_rot = x + ys;
      y_rot = y - xs;
      z_rot = z + atan;
    end
  end

endmodule

// File: rtl/vectoring.sv
// CORDIC vectoring: {x,y} -> magnitude, atan2 angle; done ITERATIONS+1 edges after start.
// start is ignored while busy (no queuing); results hold until the next done pulse.
module vectoring
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 16,
  parameter int GUARD      = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] vector_arg,
  output logic        busy,
  output logic        done,
  output logic [15:0] magnitude,
  output logic [31:0] angle
);

  localparam int W  = 18 + GUARD;
  localparam int P  = W + 17;
  localparam int SH = 15 + GUARD;
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);
  localparam logic signed [P-1:0] HALF = {{(P-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};

  state_t              state;
  logic [4:0]          cnt;
  logic signed [W-1:0] x, y;
  logic [31:0]         z;
  logic                zero_flag;

  logic signed [W-1:0] x_in, y_in, x_neg, y_neg, x_rot, y_rot;
  logic [31:0]         z_rot, atan_i;
  logic signed [P-1:0] prod, mag_q;
  logic [15:0]         mag_sat;

  // Two extra integer bits absorb the CORDIC gain times sqrt(2) and the -(-32768) case.
  assign x_in  = {{(W-16-GUARD){vector_arg[31]}}, vector_arg[31:16], {GUARD{1'b0}}};
  assign y_in  = {{(W-16-GUARD){vector_arg[15]}}, vector_arg[15:0], {GUARD{1'b0}}};
  assign x_neg = -x_in;
  assign y_neg = -y_in;

  assign atan_i = atan_lut(cnt);

  cordic_microrot #(.W(W)) u_microrot (
    .x     (x),
    .y     (y),
    .z     (z),
    .shift (cnt),
    .ccw   (y[W-1]),
    .atan  (atan_i),
    .x_rot (x_rot),
    .y_rot (y_rot),
    .z_rot (z_rot)
  );

  assign prod  = P'(x) * P'($signed({1'b0, KINV}));
  assign mag_q = (prod + HALF) >>> SH;

  always_comb begin
    mag_sat = mag_q[15:0];
    if (mag_q[P-1])
      mag_sat = 16'h0000;
    else if (|mag_q[P-2:16])
      mag_sat = 16'hFFFF;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      magnitude <= '0;
      angle     <= '0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      zero_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Pre-rotate left-half-plane inputs by +/-90 deg so iterations converge.
            if (!x_in[W-1]) begin
              x <= x_in;  y <= y_in;  z <= '0;
            end else if (!y_in[W-1]) begin
              x <= y_in;  y <= x_neg; z <= ANGLE_90;
            end else begin
              x <= y_neg; y <= x_in;  z <= ANGLE_M90;
            end
            zero_flag <= (vector_arg == 32'h0);
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ROTATE;
          end
        end
        ROTATE: begin
          x   <= x_rot;
          y   <= y_rot;
          z   <= z_rot;
          cnt <= cnt + 5'd1;
          if (cnt == LAST)
            state <= SCALE;
        end
        SCALE: begin
          magnitude <= zero_flag ? 16'h0000 : mag_sat;
          angle     <= zero_flag ? 32'h0    : z;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vectoring.md
Name: vectoring

Overview:
- Iterative CORDIC vectoring-mode engine; the inverse direction of the rotation block.
- Takes a packed signed vector {x,y} and returns its magnitude and its angle atan2(y,x).
- Angle uses the same 32-bit binary-angle format as the rotation block's angle_arg, so rotation(vector, angle) reconstructs the input vector.
- One micro-rotation per clock, with start/busy/done handshake.

Parameters:
- ITERATIONS, 16: number of micro-rotations. Legal range 1..24; the atan table holds 24 entries.
- GUARD, 4: extra fractional LSBs carried on the internal x/y datapath.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- vector_arg  in  32  [31:16]=x, [15:0]=y, both signed two's complement; same packing as rotation.vector_arg.
- busy  out  1  high while a computation is in flight.
- done  out  1  one-cycle pulse when magnitude/angle are updated.
- magnitude  out  16  unsigned, gain-compensated sqrt(x^2+y^2); held until next done.
- angle  out  32  signed binary angle, 2^32 = full circle, 0x40000000 = +90 deg, 0x80000000 = ±180 deg; held until next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, magnitude=0, angle=0, iteration counter=0, internal x/y/z=0.
- Reset mid-operation aborts the computation; no done is emitted.
- Internal datapath:
  - x,y are 18+GUARD bits signed: input << GUARD, sign-extended by 2 integer bits to absorb gain 1.647*sqrt(2).
  - z is 32 bits; wraps modulo 2^32 by design.
- States:
  - IDLE: done=0 except the cycle immediately following SCALE.
  - IDLE -> ROTATE on start=1 at edge T. vector_arg is captured with quadrant pre-rotation:
    - x>=0: x'=x, y'=y, z=0.
    - x<0, y>=0: x'=y, y'=-x, z=0x40000000.
    - x<0, y<0: x'=-y, y'=x, z=0xC0000000.
    - Capture also sets zero_flag if x==0 && y==0.
    - busy=1 from edge T.
  - ROTATE: for i = 0..ITERATIONS-1, one per edge:
    - y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
    - y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
    - Shifts are arithmetic; both updates use the old x,y.
    - After the last iteration -> SCALE.
  - SCALE (one edge, T+ITERATIONS+1):
    - magnitude = round((x * KINV) >> (15+GUARD)), with KINV = 0x4DBA (0.60725 in Q1.15), saturated to 0xFFFF.
    - angle = z.
    - If zero_flag: magnitude=0, angle=0.
    - done=1, busy=0, state -> IDLE.
- Latency: start edge to done-high cycle is ITERATIONS+1 edges (17 at default). Throughput: one result per ITERATIONS+2 cycles.
- start while busy=1 is ignored; no queuing.
- start asserted in the done cycle is accepted (state is IDLE).
- vector_arg is sampled only at the accepting edge; later changes have no effect.
- Extreme input x=-32768, y=0: internal y'=+32768 fits the widened path; result angle ≈ 0x80000000, magnitude ≈ 32768.
- Accuracy at ITERATIONS=16:
  - angle within ±2^17 units (~0.011 deg) of ideal, modulo 2^32.
  - magnitude within ±2 LSB of ideal.

Decomposition:
- Shared package cordic_pkg, reused by rotation:
  - ATAN table: 24 x 32-bit, round(atan(2^-i)*2^32/(2*pi)).
  - KINV constant.
  - ANGLE_90 / ANGLE_M90 constants.
  - State encoding localparams.
- One natural sub-module: cordic_microrot. Combinational x/y/z update given shift i, direction bit, and ATAN[i]; also usable by rotation with direction taken from sign(z).
- The counter, FSM and scaling stay in vectoring.

Test Plan:
- Reset: hold reset_n=0 mid-ROTATE, release -> busy=0, done=0, magnitude=0, angle=0; no done for the aborted job.
- x=16384, y=0, start -> done exactly 17 cycles later; magnitude 16384±2, angle 0±2^17.
- x=-10000, y=10000 -> magnitude 14142±2, angle 0x60000000±2^17 (135 deg). x=-10000, y=-10000 -> angle 0xA0000000±2^17.
- x=0, y=0 -> magnitude 0, angle exactly 0. x=-32768, y=0 -> magnitude 32768±2, angle 0x80000000±2^17.
- Pulse start on every cycle during busy -> exactly one done. Start in the done cycle -> second job completes 17 cycles later; outputs hold between dones.
- Random 10,000 vectors vs. a real-valued model -> all within tolerance. Feed (magnitude, angle) to rotation -> reconstructs the input within ±4 LSB per component.
